multdiv_unit: RTL and testbench

- Iterative signed multiply/divide engine for the processor's multdiv path. It sits downstream of the cycle-step counter function and consumes a step count.
- Accepts one-cycle ctrl_MULT/ctrl_DIV start pulses with 32-bit operands from the execute stage.
- Sequences a radix-4 Booth multiply or a restoring divide over many cycles.
- Returns a result, an exception flag and a ready flag to the pipeline stall logic.

---
 rtl/multdiv_pkg.sv | 38 +++
 rtl/multdiv_step_counter.sv | 28 ++
 rtl/multdiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_multdiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants, FSM state encoding and radix-4 Booth recoding for the
// iterative multiply/divide unit.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_MULT_STEPS = DEFAULT_WIDTH / 2;
  localparam int DEFAULT_DIV_STEPS  = DEFAULT_WIDTH;
  localparam int CNT_WIDTH          = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_PLUS_A,
    BOOTH_PLUS_2A,
    BOOTH_MINUS_A,
    BOOTH_MINUS_2A
  } booth_op_e;

  // Window is {b[i+1], b[i], b[i-1]} of the multiplier.
  function automatic booth_op_e booth_recode(input logic [2:0] window);
    booth_op_e op;
    case (window)
      3'b001, 3'b010: op = BOOTH_PLUS_A;
      3'b011:         op = BOOTH_PLUS_2A;
      3'b100:         op = BOOTH_MINUS_2A;
      3'b101, 3'b110: op = BOOTH_MINUS_A;
      default:        op = BOOTH_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multdiv_step_counter.sv
// Saturating step counter: synchronous clear, count enable and a
// terminal-count flag that also stops further counting.
module multdiv_step_counter
  import multdiv_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 terminal
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == limit);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) and divide (restoring, on
// magnitudes) engine with a sticky result-ready flag.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MULT_STEPS = WIDTH / 2,
  parameter int DIV_STEPS  = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_inputRDY
);

  localparam logic [CNT_WIDTH-1:0] MULT_TC  = CNT_WIDTH'(MULT_STEPS);
  localparam logic [CNT_WIDTH-1:0] DIV_TC   = CNT_WIDTH'(DIV_STEPS);
  localparam logic [WIDTH-1:0]     MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state, state_next;

  logic                 start;
  logic                 step_done;
  logic                 count_enable;
  logic [CNT_WIDTH-1:0] step_limit;

  logic [WIDTH-1:0] mult_a;
  logic [WIDTH+1:0] mult_hi;
  logic [WIDTH:0]   mult_lo;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] booth_addend;
  logic [WIDTH+1:0] booth_sum;
  logic [WIDTH+1:0] next_hi;
  logic [WIDTH:0]   next_lo;
  logic             mult_ovf;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] div_b;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_neg;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  assign start        = ctrl_MULT | ctrl_DIV;
  assign count_enable = (state == MULT) || (state == DIV);
  assign step_limit   = (state == DIV) ? DIV_TC : MULT_TC;

  multdiv_step_counter u_step_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (start),
    .enable   (count_enable),
    .limit    (step_limit),
    .terminal (step_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new start pulse always wins, aborting whatever is in flight.
  always_comb begin
    state_next = state;
    if (ctrl_MULT) begin
      state_next = MULT;
    end else if (ctrl_DIV) begin
      state_next = DIV;
    end else begin
      case (state)
        MULT:    if (step_done) state_next = DONE;
        DIV:     if (div_zero || step_done) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  // Accumulator carries two guard bits so that +/-2A never overflows.
  always_comb begin
    a_ext        = {{2{mult_a[WIDTH-1]}}, mult_a};
    booth_addend = '0;
    case (booth_recode(mult_lo[2:0]))
      BOOTH_PLUS_A:   booth_addend = a_ext;
      BOOTH_PLUS_2A:  booth_addend = {a_ext[WIDTH:0], 1'b0};
      BOOTH_MINUS_A:  booth_addend = -a_ext;
      BOOTH_MINUS_2A: booth_addend = -{a_ext[WIDTH:0], 1'b0};
      default:        booth_addend = '0;
    endcase
    booth_sum = mult_hi + booth_addend;
    next_hi   = {booth_sum[WIDTH+1], booth_sum[WIDTH+1], booth_sum[WIDTH+1:2]};
    next_lo   = {booth_sum[1:0], mult_lo[WIDTH:2]};
    mult_ovf  = !((&{mult_hi[WIDTH-1:0], mult_lo[WIDTH]}) ||
                  (~|{mult_hi[WIDTH-1:0], mult_lo[WIDTH]}));
  end

  always_comb begin
    mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    div_shift = {div_rem, div_quo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, div_b});
    div_diff  = div_shift[WIDTH-1:0] - div_b;
  end

  // Outputs are cleared on start and only loaded again on entry to DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mult_a         <= '0;
      mult_hi        <= '0;
      mult_lo        <= '0;
      div_b          <= '0;
      div_quo        <= '0;
      div_rem        <= '0;
      div_neg        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (ctrl_MULT) begin
      mult_a         <= data_operandA;
      mult_hi        <= '0;
      mult_lo        <= {data_operandB, 1'b0};
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (ctrl_DIV) begin
      div_b          <= mag_b;
      div_quo        <= mag_a;
      div_rem        <= '0;
      div_neg        <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero       <= (data_operandB == '0);
      div_ovf        <= (data_operandA == MOST_NEG) && (&data_operandB);
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        MULT: begin
          if (!step_done) begin
            mult_hi <= next_hi;
            mult_lo <= next_lo;
          end else begin
            data_result    <= mult_lo[WIDTH:1];
            data_exception <= mult_ovf;
            data_resultRDY <= 1'b1;
          end
        end
        DIV: begin
          if (div_zero) begin
            data_result    <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
          end else if (!step_done) begin
            div_rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            div_quo <= {div_quo[WIDTH-2:0], div_ge};
          end else begin
            data_result    <= div_neg ? -div_quo : div_quo;
            data_exception <= div_ovf;
            data_resultRDY <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_inputRDY = (state == IDLE) || (state == DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized self-checking bench for multdiv_unit: an arithmetic reference
// model predicts every output on every cycle, plus hand-computed checks.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_inputRDY;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_result  = '0;
  logic        exp_exc     = 1'b0;
  logic        exp_rdy     = 1'b0;
  logic        exp_inrdy   = 1'b1;
  logic [31:0] pend_result = '0;
  logic        pend_exc    = 1'b0;
  int          remaining   = 0;

  always #5 clock = ~clock;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_inputRDY  (data_inputRDY)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Result, exception flag and edges from start to ready, from plain arithmetic.
  function automatic void predict(input logic is_mult, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic e, output int latency);
    logic signed [63:0] p;
    int qa;
    int qb;
    if (is_mult) begin
      p = $signed(a) * $signed(b);
      r = p[31:0];
      e = !((&p[63:31]) || (~|p[63:31]));
      latency = 17;
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
      latency = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
      latency = 33;
    end else begin
      qa = a;
      qb = b;
      r = qa / qb;
      e = 1'b0;
      latency = 33;
    end
  endfunction

  // Reference model plus the per-cycle compare of every output.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_result = '0;
      exp_exc    = 1'b0;
      exp_rdy    = 1'b0;
      exp_inrdy  = 1'b1;
      remaining  = 0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      predict(ctrl_MULT, data_operandA, data_operandB, pend_result, pend_exc, remaining);
      exp_result = '0;
      exp_exc    = 1'b0;
      exp_rdy    = 1'b0;
      exp_inrdy  = 1'b0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        exp_result = pend_result;
        exp_exc    = pend_exc;
        exp_rdy    = 1'b1;
        exp_inrdy  = 1'b1;
      end
    end
    #1;
    check_output("cyc_result", data_result, exp_result);
    check_output("cyc_exception", {31'd0, data_exception}, {31'd0, exp_exc});
    check_output("cyc_resultRDY", {31'd0, data_resultRDY}, {31'd0, exp_rdy});
    check_output("cyc_inputRDY", {31'd0, data_inputRDY}, {31'd0, exp_inrdy});
  end

  // Called at a falling edge; the pulse is seen by the next rising edge.
  task automatic apply_stimulus(input logic m, input logic d,
                                input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    while (!data_resultRDY && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    if (!data_resultRDY) check_output("ready_timeout", {31'd0, data_resultRDY}, 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = $urandom_range(0, 40);
      5:       v = -$urandom_range(1, 40);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int cycles;
    int op;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    apply_stimulus(1'b1, 1'b0, 32'd7, 32'd6);
    wait_ready(40, cycles);
    check_output("mult_7x6_latency", 32'(cycles), 32'd17);
    check_output("mult_7x6_result", data_result, 32'h0000_002A);
    check_output("mult_7x6_exc", {31'd0, data_exception}, 32'd0);

    apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5);
    wait_ready(40, cycles);
    check_output("mult_neg3x5_result", data_result, 32'hFFFF_FFF1);
    check_output("mult_neg3x5_exc", {31'd0, data_exception}, 32'd0);

    apply_stimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_ready(40, cycles);
    check_output("mult_ovf_result", data_result, 32'h0000_0000);
    check_output("mult_ovf_exc", {31'd0, data_exception}, 32'd1);

    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(40, cycles);
    check_output("div_neg7by2_latency", 32'(cycles), 32'd33);
    check_output("div_neg7by2_result", data_result, 32'hFFFF_FFFD);
    check_output("div_neg7by2_exc", {31'd0, data_exception}, 32'd0);

    apply_stimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(40, cycles);
    check_output("div_minbym1_latency", 32'(cycles), 32'd33);
    check_output("div_minbym1_result", data_result, 32'h8000_0000);
    check_output("div_minbym1_exc", {31'd0, data_exception}, 32'd1);

    apply_stimulus(1'b0, 1'b1, 32'd5, 32'd0);
    wait_ready(40, cycles);
    check_output("div_by0_latency", 32'(cycles), 32'd1);
    repeat (10) @(negedge clock);
    check_output("div_by0_result", data_result, 32'd0);
    check_output("div_by0_exc", {31'd0, data_exception}, 32'd1);
    check_output("div_by0_rdy", {31'd0, data_resultRDY}, 32'd1);

    apply_stimulus(1'b1, 1'b0, 32'd7, 32'd6);
    repeat (4) @(negedge clock);
    apply_stimulus(1'b0, 1'b1, 32'd100, 32'd7);
    wait_ready(40, cycles);
    check_output("abort_latency", 32'(cycles), 32'd33);
    check_output("abort_result", data_result, 32'h0000_000E);

    apply_stimulus(1'b1, 1'b1, 32'd9, 32'd3);
    wait_ready(40, cycles);
    check_output("both_pulses_result", data_result, 32'd27);

    apply_stimulus(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_output("midreset_result", data_result, 32'd0);
    check_output("midreset_exc", {31'd0, data_exception}, 32'd0);
    check_output("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check_output("midreset_inrdy", {31'd0, data_inputRDY}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 32'd2, 32'd3);
    wait_ready(40, cycles);
    check_output("post_reset_mult", data_result, 32'd6);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      apply_stimulus(op == 0 || op == 1 || op == 4, op == 2 || op == 3 || op == 4,
                     pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 15)) @(negedge clock);
      end else begin
        wait_ready(40, cycles);
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
    end
    wait_ready(40, cycles);
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
